// File: rtl/cmp_seq_pkg.sv
// Shared definitions for the sequential max/min compare controller:
// FSM state encoding and sample data width.
package cmp_seq_pkg;

  localparam int DW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mag_cmp4.sv
// Unsigned magnitude comparator: reports a > b and a == b for DW-bit operands.
module mag_cmp4
  import cmp_seq_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          gt,
  output logic          eq
);

  assign gt = (a > b);
  assign eq = (a == b);

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Scans a run of N samples and reports the largest value and its first index.
// Optional minimum tracking is enabled by defining CMP_SEQ_MIN_TRACK_EN.
module cmp_seq_ctrl
  import cmp_seq_pkg::*;
#(
  parameter  int N    = 8,
  localparam int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   max_val,
  output logic [IDXW-1:0] max_idx
`ifdef CMP_SEQ_MIN_TRACK_EN
  ,
  output logic [DW-1:0]   min_val,
  output logic [IDXW-1:0] min_idx
`endif
);

  // One spare counter bit so the count never wraps inside a run.
  localparam int            CW   = IDXW + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [DW-1:0]   max_val_reg, max_val_next;
  logic [IDXW-1:0] max_idx_reg, max_idx_next;
  logic            max_gt, max_eq;
  logic            first_sample;

  mag_cmp4 u_max_cmp (
    .a  (in_data),
    .b  (max_val_reg),
    .gt (max_gt),
    .eq (max_eq)
  );

`ifdef CMP_SEQ_MIN_TRACK_EN
  logic [DW-1:0]   min_val_reg, min_val_next;
  logic [IDXW-1:0] min_idx_reg, min_idx_next;
  logic            min_gt, min_eq;

  // Operands swapped: replace when the stored minimum exceeds the new sample.
  mag_cmp4 u_min_cmp (
    .a  (min_val_reg),
    .b  (in_data),
    .gt (min_gt),
    .eq (min_eq)
  );
`endif

  assign first_sample = (count_reg == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      max_val_reg <= '0;
      max_idx_reg <= '0;
`ifdef CMP_SEQ_MIN_TRACK_EN
      min_val_reg <= '0;
      min_idx_reg <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      max_val_reg <= max_val_next;
      max_idx_reg <= max_idx_next;
`ifdef CMP_SEQ_MIN_TRACK_EN
      min_val_reg <= min_val_next;
      min_idx_reg <= min_idx_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    max_val_next = max_val_reg;
    max_idx_next = max_idx_reg;
`ifdef CMP_SEQ_MIN_TRACK_EN
    min_val_next = min_val_reg;
    min_idx_next = min_idx_reg;
`endif
    in_ready     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SCAN;
          count_next = '0;
        end
      end
      SCAN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        // Abort wins over a sample offered in the same cycle.
        if (abort) begin
          state_next = IDLE;
        end else if (in_valid) begin
          count_next = count_reg + 1'b1;
          if (count_reg == LAST) begin
            state_next = DONE;
          end
          if (first_sample || (max_gt && !max_eq)) begin
            max_val_next = in_data;
            max_idx_next = count_reg[IDXW-1:0];
          end
`ifdef CMP_SEQ_MIN_TRACK_EN
          if (first_sample || (min_gt && !min_eq)) begin
            min_val_next = in_data;
            min_idx_next = count_reg[IDXW-1:0];
          end
`endif
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign max_val = max_val_reg;
  assign max_idx = max_idx_reg;
`ifdef CMP_SEQ_MIN_TRACK_EN
  assign min_val = min_val_reg;
  assign min_idx = min_idx_reg;
`endif

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Directed self-checking bench for cmp_seq_ctrl with N=4 samples per run.
module tb_cmp_seq_ctrl;

  localparam int N    = 4;
  localparam int IDXW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            in_valid = 1'b0;
  logic [3:0]      in_data = 4'd0;
  logic            in_ready, busy, done;
  logic [3:0]      max_val;
  logic [IDXW-1:0] max_idx;
`ifdef CMP_SEQ_MIN_TRACK_EN
  logic [3:0]      min_val;
  logic [IDXW-1:0] min_idx;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cmp_seq_ctrl #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .max_val  (max_val),
    .max_idx  (max_idx)
`ifdef CMP_SEQ_MIN_TRACK_EN
    ,
    .min_val  (min_val),
    .min_idx  (min_idx)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    if (busy !== 1'b0) begin $display("FAIL reset_busy got=%0b want=0", busy); errors++; end
    checks++;
    if (in_ready !== 1'b0) begin $display("FAIL reset_in_ready got=%0b want=0", in_ready); errors++; end
    checks++;
    if (done !== 1'b0) begin $display("FAIL reset_done got=%0b want=0", done); errors++; end
    checks++;
    if (max_val !== 4'd0) begin $display("FAIL reset_max_val got=%0d want=0", max_val); errors++; end
    checks++;
    if (max_idx !== 2'd0) begin $display("FAIL reset_max_idx got=%0d want=0", max_idx); errors++; end
    checks++;
    rst = 1'b0;
    step();
    $display("reset: busy=%0b done=%0b max_val=%0d", busy, done, max_val);
  endtask

  task automatic test_basic;
    begin_run();
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      $display("FAIL basic_scan busy=%0b in_ready=%0b want=1,1", busy, in_ready); errors++;
    end
    checks++;
    send(4'd3); send(4'd9); send(4'd1);
    if (done !== 1'b0) begin $display("FAIL basic_early_done got=%0b want=0", done); errors++; end
    checks++;
    send(4'd7);
    if (done !== 1'b1) begin $display("FAIL basic_done got=%0b want=1", done); errors++; end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      $display("FAIL basic_done_state busy=%0b in_ready=%0b want=0,0", busy, in_ready); errors++;
    end
    checks++;
    if (max_val !== 4'd9) begin $display("FAIL basic_max_val got=%0d want=9", max_val); errors++; end
    checks++;
    if (max_idx !== 2'd1) begin $display("FAIL basic_max_idx got=%0d want=1", max_idx); errors++; end
    checks++;
`ifdef CMP_SEQ_MIN_TRACK_EN
    if (min_val !== 4'd1 || min_idx !== 2'd2) begin
      $display("FAIL basic_min got=%0d@%0d want=1@2", min_val, min_idx); errors++;
    end
    checks++;
`endif
    $display("basic 3,9,1,7: done=%0b max_val=%0d max_idx=%0d", done, max_val, max_idx);
    step();
    if (done !== 1'b0) begin $display("FAIL basic_done_pulse got=%0b want=0", done); errors++; end
    checks++;
  endtask

  task automatic test_ties;
    begin_run();
    send(4'd5); send(4'd5); send(4'd5); send(4'd5);
    if (done !== 1'b1) begin $display("FAIL ties_done got=%0b want=1", done); errors++; end
    checks++;
    if (max_val !== 4'd5 || max_idx !== 2'd0) begin
      $display("FAIL ties_max got=%0d@%0d want=5@0", max_val, max_idx); errors++;
    end
    checks++;
`ifdef CMP_SEQ_MIN_TRACK_EN
    if (min_val !== 4'd5 || min_idx !== 2'd0) begin
      $display("FAIL ties_min got=%0d@%0d want=5@0", min_val, min_idx); errors++;
    end
    checks++;
`endif
    $display("ties 5,5,5,5: max_val=%0d max_idx=%0d", max_val, max_idx);
    step();
  endtask

  task automatic test_valid_gaps;
    logic       vld [7];
    logic [3:0] dat [4];
    int         k;
    vld = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    dat = '{4'd2, 4'd4, 4'd6, 4'd8};
    k   = 0;
    begin_run();
    for (int i = 0; i < 7; i++) begin
      in_valid = vld[i];
      // Idle cycles carry 15 so any wrongly accepted sample would show as the max.
      in_data  = vld[i] ? dat[k] : 4'd15;
      if (vld[i]) k++;
      step();
      if (i < 6 && busy !== 1'b1) begin
        $display("FAIL gaps_busy cycle=%0d got=%0b want=1", i, busy); errors++;
      end
      if (i < 6) checks++;
    end
    in_valid = 1'b0;
    if (done !== 1'b1) begin $display("FAIL gaps_done got=%0b want=1", done); errors++; end
    checks++;
    if (max_val !== 4'd8 || max_idx !== 2'd3) begin
      $display("FAIL gaps_max got=%0d@%0d want=8@3", max_val, max_idx); errors++;
    end
    checks++;
`ifdef CMP_SEQ_MIN_TRACK_EN
    if (min_val !== 4'd2 || min_idx !== 2'd0) begin
      $display("FAIL gaps_min got=%0d@%0d want=2@0", min_val, min_idx); errors++;
    end
    checks++;
`endif
    $display("gaps 2,4,6,8: done=%0b max_val=%0d max_idx=%0d", done, max_val, max_idx);
    step();
  endtask

  task automatic test_abort;
    begin_run();
    send(4'd1); send(4'd15);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'd0;
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      $display("FAIL abort_state busy=%0b in_ready=%0b done=%0b want=0,0,0", busy, in_ready, done);
      errors++;
    end
    checks++;
    if (max_val !== 4'd15 || max_idx !== 2'd1) begin
      $display("FAIL abort_hold got=%0d@%0d want=15@1", max_val, max_idx); errors++;
    end
    checks++;
    step();
    if (done !== 1'b0) begin $display("FAIL abort_no_done got=%0b want=0", done); errors++; end
    checks++;
    $display("abort after 1,15: busy=%0b done=%0b", busy, done);
    begin_run();
    if (max_val !== 4'd15) begin $display("FAIL rerun_hold got=%0d want=15", max_val); errors++; end
    checks++;
    send(4'd0); send(4'd0); send(4'd2); send(4'd0);
    if (done !== 1'b1) begin $display("FAIL rerun_done got=%0b want=1", done); errors++; end
    checks++;
    if (max_val !== 4'd2 || max_idx !== 2'd2) begin
      $display("FAIL rerun_max got=%0d@%0d want=2@2", max_val, max_idx); errors++;
    end
    checks++;
`ifdef CMP_SEQ_MIN_TRACK_EN
    if (min_val !== 4'd0 || min_idx !== 2'd0) begin
      $display("FAIL rerun_min got=%0d@%0d want=0@0", min_val, min_idx); errors++;
    end
    checks++;
`endif
    $display("rerun 0,0,2,0: max_val=%0d max_idx=%0d", max_val, max_idx);
    step();
  endtask

  task automatic test_reset_mid;
    begin_run();
    send(4'd6); send(4'd12);
    #2;
    rst = 1'b1;
    #1;
    if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      $display("FAIL midrst_ctrl busy=%0b in_ready=%0b done=%0b want=0,0,0", busy, in_ready, done);
      errors++;
    end
    checks++;
    if (max_val !== 4'd0 || max_idx !== 2'd0) begin
      $display("FAIL midrst_max got=%0d@%0d want=0@0", max_val, max_idx); errors++;
    end
    checks++;
`ifdef CMP_SEQ_MIN_TRACK_EN
    if (min_val !== 4'd0 || min_idx !== 2'd0) begin
      $display("FAIL midrst_min got=%0d@%0d want=0@0", min_val, min_idx); errors++;
    end
    checks++;
`endif
    #1;
    rst = 1'b0;
    step();
    $display("mid-run reset: busy=%0b max_val=%0d", busy, max_val);
  endtask

  task automatic test_start_ignored;
    begin_run();
    send(4'd4);
    start = 1'b1;
    send(4'd10);
    start = 1'b0;
    send(4'd3);
    if (busy !== 1'b1 || done !== 1'b0) begin
      $display("FAIL startign_scan busy=%0b done=%0b want=1,0", busy, done); errors++;
    end
    checks++;
    send(4'd10);
    if (done !== 1'b1) begin $display("FAIL startign_done got=%0b want=1", done); errors++; end
    checks++;
    if (max_val !== 4'd10 || max_idx !== 2'd1) begin
      $display("FAIL startign_max got=%0d@%0d want=10@1", max_val, max_idx); errors++;
    end
    checks++;
    $display("start during scan 4,10,3,10: done=%0b max_val=%0d max_idx=%0d", done, max_val, max_idx);
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_valid_gaps();
    test_abort();
    test_reset_mid();
    test_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
